// File: rtl/alu_rs.sv
// ALU reservation station: buffers decoded ALU ops, snoops the CDB for pending operands,
// dispatches one ready entry per cycle and pairs the ALU result with its RoB tag.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 RoB_clear,
  input  logic                 issue_valid,
  input  logic [5:0]           issue_op,
  input  logic [31:0]          issue_vj,
  input  logic                 issue_qj_valid,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic [31:0]          issue_vk,
  input  logic                 issue_qk_valid,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic [31:0]          issue_imm,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob_id,
  input  logic [31:0]          cdb_value,
  output logic [31:0]          alu_vj,
  output logic [31:0]          alu_vk,
  output logic [31:0]          alu_imm,
  output logic [5:0]           alu_op,
  output logic                 alu_waiting,
  input  logic                 alu_finish,
  input  logic [31:0]          alu_value,
  output logic                 result_valid,
  output logic [ROB_WIDTH-1:0] result_rob_id,
  output logic [31:0]          result_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   qj_valid;
  logic [RS_SIZE-1:0]   qk_valid;
  logic [5:0]           op     [RS_SIZE];
  logic [31:0]          vj     [RS_SIZE];
  logic [31:0]          vk     [RS_SIZE];
  logic [31:0]          imm    [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj     [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk     [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_id [RS_SIZE];

  logic [RS_SIZE-1:0]   ready;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     disp_idx;
  logic                 disp_found;
  logic                 issue_fire;
  logic                 bypass_j;
  logic                 bypass_k;

  logic                 stage1_valid;
  logic                 stage2_valid;
  logic [ROB_WIDTH-1:0] stage1_tag;
  logic [ROB_WIDTH-1:0] stage2_tag;

  assign ready      = busy & ~qj_valid & ~qk_valid;
  assign full       = &busy;
  assign disp_found = |ready;
  assign issue_fire = issue_valid && !full;
  assign bypass_j   = cdb_valid && issue_qj_valid && (cdb_rob_id == issue_qj);
  assign bypass_k   = cdb_valid && issue_qk_valid && (cdb_rob_id == issue_qk);

  // Scanning downward lets the lowest index win for both the free slot and the dispatch pick.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i])
        free_idx = IDX_W'(i);
      if (ready[i])
        disp_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || RoB_clear) begin
      busy         <= '0;
      qj_valid     <= '0;
      qk_valid     <= '0;
      alu_vj       <= '0;
      alu_vk       <= '0;
      alu_imm      <= '0;
      alu_op       <= '0;
      alu_waiting  <= 1'b0;
      stage1_valid <= 1'b0;
      stage2_valid <= 1'b0;
      stage1_tag   <= '0;
      stage2_tag   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && cdb_valid) begin
          if (qj_valid[i] && (qj[i] == cdb_rob_id)) begin
            vj[i]       <= cdb_value;
            qj_valid[i] <= 1'b0;
          end
          if (qk_valid[i] && (qk[i] == cdb_rob_id)) begin
            vk[i]       <= cdb_value;
            qk_valid[i] <= 1'b0;
          end
        end
      end

      if (disp_found) begin
        alu_vj         <= vj[disp_idx];
        alu_vk         <= vk[disp_idx];
        alu_imm        <= imm[disp_idx];
        alu_op         <= op[disp_idx];
        alu_waiting    <= 1'b1;
        busy[disp_idx] <= 1'b0;
        stage1_tag     <= rob_id[disp_idx];
      end else begin
        alu_waiting <= 1'b0;
      end
      stage1_valid <= disp_found;
      stage2_valid <= stage1_valid;
      stage2_tag   <= stage1_tag;

      // A free slot is never busy, so this cannot collide with the dispatch or snoop writes.
      if (issue_fire) begin
        busy[free_idx]     <= 1'b1;
        op[free_idx]       <= issue_op;
        imm[free_idx]      <= issue_imm;
        rob_id[free_idx]   <= issue_rob_id;
        qj[free_idx]       <= issue_qj;
        qk[free_idx]       <= issue_qk;
        vj[free_idx]       <= bypass_j ? cdb_value : issue_vj;
        vk[free_idx]       <= bypass_k ? cdb_value : issue_vk;
        qj_valid[free_idx] <= issue_qj_valid && !bypass_j;
        qk_valid[free_idx] <= issue_qk_valid && !bypass_k;
      end
    end
  end

  assign result_valid  = alu_finish && stage2_valid;
  assign result_rob_id = stage2_tag;
  assign result_value  = alu_value;

endmodule
